pipelined_prefix_subtractor: RTL and testbench

Pipelined N-bit unsigned/two's-complement subtractor computing `a - b - bin` with a Kogge-Stone borrow-lookahead prefix network. Each prefix level sits behind a register. It is the subtract-direction counterpart of the team's prefix adder and feeds the ALU compare/branch path, which needs borrow, zero and signed-overflow flags. Valid/ready handshakes on both sides; one result per cycle at full throughput.

---
 rtl/pipelined_prefix_subtractor_pkg.sv | 25 ++
 rtl/pipelined_prefix_subtractor_if.sv | 30 +++
 rtl/pipelined_prefix_subtractor_stage.sv | 82 ++++++++
 rtl/pipelined_prefix_subtractor.sv | 115 +++++++++++
 tb/tb_pipelined_prefix_subtractor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_prefix_subtractor_pkg.sv
// Purpose: shared arithmetic types and helpers for the prefix subtractor/adder family.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package arith_pkg;

    // One bit (or one span) of borrow generate/propagate.
    typedef struct packed {
        logic g;
        logic p;
    } borrow_gp_t;

    // Number of Kogge-Stone levels needed to cover an n-bit operand.
    function automatic int prefix_stages(int n);
        return $clog2(n);
    endfunction

    // Combine a high span with the adjacent lower span.
    function automatic borrow_gp_t gp_combine(borrow_gp_t hi, borrow_gp_t lo);
        borrow_gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_prefix_subtractor_if.sv
// Purpose: operand/result handshake bundle for the pipelined prefix subtractor.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface pipelined_prefix_subtractor_if #(
    parameter int NBIT = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] diff;
    logic            bout;
    logic            zero;
    logic            ovf;

    // Producer/consumer side (drives operands, takes results).
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/pipelined_prefix_subtractor_stage.sv
// Purpose: one Kogge-Stone borrow prefix level followed by its pipeline register.
// Latency: 1 cycle.
// Backpressure: holds all state while i_en is low.
module borrow_prefix_stage
    import arith_pkg::*;
#(
    parameter int NBIT = 32,
    parameter int DIST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_vld,
    input  logic [NBIT-1:0] i_g,
    input  logic [NBIT-1:0] i_p,
    input  logic [NBIT-1:0] i_axb,
    input  logic            i_a_msb,
    input  logic            i_b_msb,
    input  logic            i_bin,
    output logic            o_vld,
    output logic [NBIT-1:0] o_g,
    output logic [NBIT-1:0] o_p,
    output logic [NBIT-1:0] o_axb,
    output logic            o_a_msb,
    output logic            o_b_msb,
    output logic            o_bin
);
    logic [NBIT-1:0] w_g;
    logic [NBIT-1:0] w_p;

    logic            r_vld;
    logic [NBIT-1:0] r_g;
    logic [NBIT-1:0] r_p;
    logic [NBIT-1:0] r_axb;
    logic            r_a_msb;
    logic            r_b_msb;
    logic            r_bin;

    // Bits at or above DIST merge with the span DIST below; lower bits already
    // hold their full prefix and pass through.
    for (genvar i = 0; i < NBIT; i++) begin : g_bit
        if (i >= DIST) begin : g_cell
            borrow_gp_t w_c;
            assign w_c    = gp_combine(borrow_gp_t'({i_g[i], i_p[i]}),
                                       borrow_gp_t'({i_g[i-DIST], i_p[i-DIST]}));
            assign w_g[i] = w_c.g;
            assign w_p[i] = w_c.p;
        end else begin : g_pass
            assign w_g[i] = i_g[i];
            assign w_p[i] = i_p[i];
        end
    end

    // Level register: clears on reset, advances only with the global enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_g     <= '0;
            r_p     <= '0;
            r_axb   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_bin   <= 1'b0;
        end else if (i_en) begin
            r_vld   <= i_vld;
            r_g     <= w_g;
            r_p     <= w_p;
            r_axb   <= i_axb;
            r_a_msb <= i_a_msb;
            r_b_msb <= i_b_msb;
            r_bin   <= i_bin;
        end
    end

    assign o_vld   = r_vld;
    assign o_g     = r_g;
    assign o_p     = r_p;
    assign o_axb   = r_axb;
    assign o_a_msb = r_a_msb;
    assign o_b_msb = r_b_msb;
    assign o_bin   = r_bin;
endmodule

// File: rtl/pipelined_prefix_subtractor.sv
// Purpose: pipelined a - b - bin with Kogge-Stone borrow lookahead plus borrow/zero/overflow flags.
// Latency: STAGES + 1 cycles from acceptance to out_valid; one result per cycle.
// Backpressure: a stalled output freezes the whole pipe (no bubble collapse); in_ready = ~out_valid | out_ready.
module pipelined_prefix_subtractor
    import arith_pkg::*;
#(
    parameter int NBIT = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipelined_prefix_subtractor_if.slave bus
);
    localparam int STAGES = prefix_stages(NBIT);

    logic            w_adv;
    logic [NBIT-1:0] w_g_raw;
    logic [NBIT-1:0] w_g_bit;
    logic [NBIT-1:0] w_p_bit;

    logic            r_vld;
    logic [NBIT-1:0] r_a;
    logic [NBIT-1:0] r_b;
    logic            r_bin;
    logic [NBIT-1:0] r_g;
    logic [NBIT-1:0] r_p;

    // Index 0 is the S0 register, index k the output of prefix level k.
    logic            w_vld   [0:STAGES];
    logic [NBIT-1:0] w_g     [0:STAGES];
    logic [NBIT-1:0] w_p     [0:STAGES];
    logic [NBIT-1:0] w_axb   [0:STAGES];
    logic            w_a_msb [0:STAGES];
    logic            w_b_msb [0:STAGES];
    logic            w_bin   [0:STAGES];

    logic [NBIT-1:0] w_brw;
    logic [NBIT-1:0] w_diff;
    logic            w_unused_p;

    // A single enable moves every stage together; empty slots are not squeezed out.
    assign w_adv        = ~w_vld[STAGES] | bus.out_ready;
    assign bus.in_ready = w_adv;

    // Bit-level borrow generate/propagate, with borrow-in folded into bit 0 so
    // the prefix tree carries it to every higher bit.
    assign w_p_bit = ~(bus.a ^ bus.b);
    assign w_g_raw = ~bus.a & bus.b;
    assign w_g_bit = {w_g_raw[NBIT-1:1], w_g_raw[0] | (w_p_bit[0] & bus.bin)};

    // S0: capture operands and bit-level G/P on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_bin <= 1'b0;
            r_g   <= '0;
            r_p   <= '0;
        end else if (w_adv) begin
            r_vld <= bus.in_valid & w_adv;
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_bin <= bus.bin;
            r_g   <= w_g_bit;
            r_p   <= w_p_bit;
        end
    end

    assign w_vld[0]   = r_vld;
    assign w_g[0]     = r_g;
    assign w_p[0]     = r_p;
    assign w_axb[0]   = r_a ^ r_b;
    assign w_a_msb[0] = r_a[NBIT-1];
    assign w_b_msb[0] = r_b[NBIT-1];
    assign w_bin[0]   = r_bin;

    for (genvar k = 1; k <= STAGES; k++) begin : g_lvl
        borrow_prefix_stage #(
            .NBIT (NBIT),
            .DIST (1 << (k - 1))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_adv),
            .i_vld   (w_vld[k-1]),
            .i_g     (w_g[k-1]),
            .i_p     (w_p[k-1]),
            .i_axb   (w_axb[k-1]),
            .i_a_msb (w_a_msb[k-1]),
            .i_b_msb (w_b_msb[k-1]),
            .i_bin   (w_bin[k-1]),
            .o_vld   (w_vld[k]),
            .o_g     (w_g[k]),
            .o_p     (w_p[k]),
            .o_axb   (w_axb[k]),
            .o_a_msb (w_a_msb[k]),
            .o_b_msb (w_b_msb[k]),
            .o_bin   (w_bin[k])
        );
    end

    // After the last level, G[i] is the borrow out of span [i:0], i.e. the
    // borrow into bit i+1; bit 0 takes the raw borrow-in.
    assign w_brw  = {w_g[STAGES][NBIT-2:0], w_bin[STAGES]};
    assign w_diff = w_axb[STAGES] ^ w_brw;

    // The final group-propagate has no consumer; kept so every level is uniform.
    assign w_unused_p = ^w_p[STAGES];

    assign bus.out_valid = w_vld[STAGES];
    assign bus.diff      = w_diff;
    assign bus.bout      = w_g[STAGES][NBIT-1];
    assign bus.zero      = ~|w_diff;
    assign bus.ovf       = (w_a_msb[STAGES] ^ w_b_msb[STAGES]) & (w_a_msb[STAGES] ^ w_diff[NBIT-1]);
endmodule

// File: tb/tb_pipelined_prefix_subtractor.sv
// Purpose: self-checking bench for pipelined_prefix_subtractor (NBIT=8 and NBIT=32 instances).
// Latency: expects 4 cycles at NBIT=8 and 6 cycles at NBIT=32.
// Backpressure: drives out_ready low mid-stream and checks freeze, in_ready and in-order delivery.
module tb_pipelined_prefix_subtractor;
    logic clk;
    logic rst_n;

    pipelined_prefix_subtractor_if #(.NBIT(8))  bus8 ();
    pipelined_prefix_subtractor_if #(.NBIT(32)) bus32 ();

    pipelined_prefix_subtractor #(.NBIT(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    pipelined_prefix_subtractor #(.NBIT(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    logic last_acc = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: wide subtract, borrow from the bit above the operand width.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        exp_t       e;
        logic [8:0] t;
        t      = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        e.diff = t[7:0];
        e.bout = t[8];
        e.zero = (t[7:0] == 8'd0);
        e.ovf  = (a[7] ^ b[7]) & (a[7] ^ t[7]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: score the result handshake and record acceptance for the
    // coming edge (sampled at negedge), then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst_n && bus8.out_valid && bus8.out_ready) begin
            chk($sformatf("op%0d_expected", n_out), 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("op%0d_diff", n_out), 32'(bus8.diff), 32'(e.diff));
                chk($sformatf("op%0d_bout", n_out), 32'(bus8.bout), 32'(e.bout));
                chk($sformatf("op%0d_zero", n_out), 32'(bus8.zero), 32'(e.zero));
                chk($sformatf("op%0d_ovf",  n_out), 32'(bus8.ovf),  32'(e.ovf));
            end
            n_out++;
        end
        last_acc = rst_n && bus8.in_valid && bus8.in_ready;
        if (last_acc) sb.push_back(pend);
        if (!rst_n) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        bus8.a   = 8'($urandom);
        bus8.b   = 8'($urandom);
        bus8.bin = 1'($urandom);
        pend     = model8(bus8.a, bus8.b, bus8.bin);
    endtask

    // Single op into an empty pipe: measures latency, then lets the scoreboard
    // compare it against the supplied expectation.
    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic bi, input exp_t e);
        int n;
        bus8.a = a; bus8.b = b; bus8.bin = bi; pend = e;
        bus8.in_valid = 1'b1;
        cycle();
        bus8.in_valid = 1'b0;
        n = 1;
        while (!bus8.out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        cycle();
    endtask

    initial begin
        int   sent, run, maxrun, base, n;
        exp_t hold, cur;

        rst_n = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.bin  = 1'b0; bus8.out_ready  = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.bin = 1'b0; bus32.out_ready = 1'b1;
        pend = '0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_diff",      32'(bus8.diff),      32'd0);
        chk("rst_bout",      32'(bus8.bout),      32'd0);
        chk("rst_zero",      32'(bus8.zero),      32'd1);
        chk("rst_ovf",       32'(bus8.ovf),       32'd0);
        chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        chk("rst32_in_ready", 32'(bus32.in_ready), 32'd1);

        // Directed NBIT=8 cases: {diff, bout, zero, ovf}
        directed("sub_pos",    8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0, 1'b0});
        directed("sub_neg",    8'h03, 8'h05, 1'b0, {8'hFE, 1'b1, 1'b0, 1'b0});
        directed("sub_ovf",    8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b0, 1'b1});
        directed("sub_ripple", 8'h10, 8'h0F, 1'b1, {8'h00, 1'b0, 1'b1, 1'b0});

        // 20 back-to-back random ops, expect one unbroken run of 20 results
        base = n_out; sent = 0; run = 0; maxrun = 0;
        drive_rand();
        bus8.in_valid = 1'b1;
        for (int c = 0; c < 40 && sent < 20; c++) begin
            cycle();
            run = bus8.out_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (last_acc) begin
                sent++;
                drive_rand();
            end
        end
        bus8.in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            run = bus8.out_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("stream_count", 32'(n_out - base), 32'd20);
        chk("stream_run",   32'(maxrun),       32'd20);

        // Backpressure mid-stream
        drive_rand();
        bus8.in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (last_acc) drive_rand();
        end
        bus8.out_ready = 1'b0;
        hold = {bus8.diff, bus8.bout, bus8.zero, bus8.ovf};
        chk("stall_out_valid", 32'(bus8.out_valid), 32'd1);
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (last_acc) drive_rand();
            cur = {bus8.diff, bus8.bout, bus8.zero, bus8.ovf};
            chk("stall_in_ready", 32'(bus8.in_ready), 32'd0);
            chk("stall_stable",   32'(cur),           32'(hold));
        end
        bus8.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (last_acc) drive_rand();
        end
        bus8.in_valid = 1'b0;
        for (int c = 0; c < 10; c++) cycle();
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Reset with two ops in flight and one op offered during reset
        bus8.in_valid = 1'b1;
        drive_rand();
        cycle();
        drive_rand();
        cycle();
        rst_n = 1'b0;
        drive_rand();
        cycle();
        rst_n = 1'b1;
        bus8.in_valid = 1'b0;
        chk("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk($sformatf("post_rst_out_valid_c%0d", c), 32'(bus8.out_valid), 32'd0);
        end

        // NBIT=32: 0 - 0 - 1
        bus32.a = '0; bus32.b = '0; bus32.bin = 1'b1;
        bus32.in_valid = 1'b1;
        cycle();
        bus32.in_valid = 1'b0;
        n = 1;
        while (!bus32.out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("w32_latency", 32'(n),          32'd6);
        chk("w32_diff",    bus32.diff,      32'hFFFF_FFFF);
        chk("w32_bout",    32'(bus32.bout), 32'd1);
        chk("w32_zero",    32'(bus32.zero), 32'd0);
        chk("w32_ovf",     32'(bus32.ovf),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
